// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter sharing one enable-gated W-bit register among N writers.
// Each grant performs exactly one write, then holds ownership for up to HOLD cycles.
module rr_reg_write_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int HOLD = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic           en,
  output logic [W-1:0]   d,
  output logic [W-1:0]   q,
  output logic           busy
);

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);
  localparam logic [NW-1:0] LAST_RST = NW'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   owner_q, owner_d;
  logic [NW-1:0]   last_q,  last_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [N-1:0]    gnt_q,   gnt_d;
  logic [W-1:0]    q_q,     q_d;

  logic            win_found;
  logic [NW-1:0]   win_idx;
  logic            release_now;

  // Scan from the farthest slot (last itself) toward last+1 so the nearest hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last_q) + k) % N]) begin
        win_found = 1'b1;
        win_idx   = NW'((int'(last_q) + k) % N);
      end
    end
  end

  assign busy = (state_q == GRANT);
  assign en   = busy && (cnt_q == '0);
  assign d    = busy ? wdata[int'(owner_q)*W +: W] : '0;
  assign gnt  = gnt_q;
  assign q    = q_q;

  assign release_now = (cnt_q == CNT_LAST) || !req[owner_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    q_d     = en ? d : q_q;

    // IDLE arbitrates directly; GRANT re-arbitrates only on release, from last == owner.
    if (state_q == IDLE || release_now) begin
      if (win_found) begin
        state_d = GRANT;
        owner_d = win_idx;
        last_d  = win_idx;
        cnt_d   = '0;
        gnt_d   = N'(1) << win_idx;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        gnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      gnt_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
    end
  end

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Directed bench for rr_reg_write_arbiter (N=4, W=8, HOLD=2) with hand-computed expectations.
module tb_rr_reg_write_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int HOLD = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic           en;
  logic [W-1:0]   d;
  logic [W-1:0]   q;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  rr_reg_write_arbiter #(.N(N), .W(W), .HOLD(HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .en    (en),
    .d     (d),
    .q     (q),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    wdata = '0;
    #1 rst = 1'b0;
    #1;
    check_eq("rst_gnt",  32'(gnt),  32'h0);
    check_eq("rst_en",   32'(en),   32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_q",    32'(q),    32'h0);
    check_eq("rst_d",    32'(d),    32'h0);

    req   = 4'b1111;
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    step();
    check_eq("held_rst_gnt", 32'(gnt), 32'h0);
    rst = 1'b1;

    // first grant after reset goes to index 0
    step();
    check_eq("a_gnt",  32'(gnt),  32'h1);
    check_eq("a_en",   32'(en),   32'h1);
    check_eq("a_busy", 32'(busy), 32'h1);
    check_eq("a_d",    32'(d),    32'h10);
    step();
    check_eq("a2_q",   32'(q),   32'h10);
    check_eq("a2_gnt", 32'(gnt), 32'h1);
    check_eq("a2_en",  32'(en),  32'h0);

    // reset in the second cycle of a grant
    #3 rst = 1'b0;
    #1;
    check_eq("mid_rst_gnt",  32'(gnt),  32'h0);
    check_eq("mid_rst_q",    32'(q),    32'h0);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    check_eq("mid_rst_en",   32'(en),   32'h0);
    req = 4'b0100;
    rst = 1'b1;
    step();
    check_eq("b_gnt", 32'(gnt), 32'h4);
    check_eq("b_en",  32'(en),  32'h1);
    check_eq("b_d",   32'(d),   32'h12);
    step();
    check_eq("b2_q",   32'(q),   32'h12);
    check_eq("b2_gnt", 32'(gnt), 32'h4);
    check_eq("b2_en",  32'(en),  32'h0);
    step();
    check_eq("b3_gnt", 32'(gnt), 32'h4);
    check_eq("b3_en",  32'(en),  32'h1);
    req = 4'b0000;
    step();
    check_eq("b4_gnt",  32'(gnt),  32'h0);
    check_eq("b4_busy", 32'(busy), 32'h0);
    check_eq("b4_q",    32'(q),    32'h12);

    // single requester 1 re-granted with a rewrite
    req   = 4'b0010;
    wdata = {8'h13, 8'h12, 8'h5A, 8'h10};
    step();
    check_eq("s_gnt", 32'(gnt), 32'h2);
    check_eq("s_en",  32'(en),  32'h1);
    check_eq("s_d",   32'(d),   32'h5A);
    step();
    check_eq("s2_q",   32'(q),   32'h5A);
    check_eq("s2_gnt", 32'(gnt), 32'h2);
    check_eq("s2_en",  32'(en),  32'h0);
    step();
    check_eq("s3_gnt", 32'(gnt), 32'h2);
    check_eq("s3_en",  32'(en),  32'h1);
    wdata = {8'h13, 8'h12, 8'h6B, 8'h10};
    #1;
    check_eq("s3_d", 32'(d), 32'h6B);
    step();
    check_eq("s4_q",   32'(q),   32'h6B);
    check_eq("s4_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    check_eq("s5_gnt", 32'(gnt), 32'h0);

    // reset with all requesting, then full contention rotation
    req   = 4'b1111;
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    rst   = 1'b0;
    #1;
    check_eq("c_rst_q",    32'(q),    32'h0);
    check_eq("c_rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      check_eq("c_gnt1", 32'(gnt), 32'(1) << (k % 4));
      check_eq("c_en1",  32'(en),  32'h1);
      check_eq("c_d1",   32'(d),   32'h10 + 32'(k % 4));
      step();
      check_eq("c_gnt2", 32'(gnt), 32'(1) << (k % 4));
      check_eq("c_en2",  32'(en),  32'h0);
      check_eq("c_q2",   32'(q),   32'h10 + 32'(k % 4));
      step();
    end
    check_eq("c_next_gnt", 32'(gnt), 32'h2);

    // owner 1 drops in its first cycle, then owner 2 drops with req[3] high
    req = 4'b1100;
    step();
    check_eq("e1_q",   32'(q),   32'h11);
    check_eq("e1_gnt", 32'(gnt), 32'h4);
    check_eq("e1_d",   32'(d),   32'h12);
    req = 4'b1000;
    step();
    check_eq("e2_q",   32'(q),   32'h12);
    check_eq("e2_gnt", 32'(gnt), 32'h8);
    check_eq("e2_en",  32'(en),  32'h1);

    // pointer wrap: last=3 so 0 wins, then 3
    req = 4'b1001;
    step();
    check_eq("w1_gnt", 32'(gnt), 32'h8);
    check_eq("w1_q",   32'(q),   32'h13);
    step();
    check_eq("w2_gnt", 32'(gnt), 32'h1);
    check_eq("w2_en",  32'(en),  32'h1);
    step();
    check_eq("w3_q",   32'(q),   32'h10);
    step();
    check_eq("w4_gnt", 32'(gnt), 32'h8);
    check_eq("w4_d",   32'(d),   32'h13);

    req = 4'b0000;
    step();
    step();
    check_eq("end_gnt",  32'(gnt),  32'h0);
    check_eq("end_busy", 32'(busy), 32'h0);
    check_eq("end_q",    32'(q),    32'h13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_reg_write_arbiter.md
# rr_reg_write_arbiter

Round-robin arbiter that shares one enable-gated W-bit storage register between N requesters. It sequences access with a small FSM and a hold counter, and drives the register's enable and data. Each grant performs exactly one write, then holds ownership for a bounded number of cycles. The block sits between independent writer agents and the shared register; the register lives inside this block so its contents are observable on `q`.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `W`, default 8: data width of the shared register.
- `HOLD`, default 2: maximum cycles a grant is held, ≥1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req` input N: per-requester request, level-sensitive.
- `wdata` input N*W: requester i data in bits [i*W +: W].
- `gnt` output N: registered one-hot grant, or all-zero.
- `en` output 1: write enable to the shared register.
- `d` output W: write data to the shared register, the granted slice of `wdata`.
- `q` output W: shared register contents.
- `busy` output 1: high whenever state is GRANT.

## Operation
- State is `{state, owner, last, cnt}`, plus the register `q`.
  - `state`: IDLE or GRANT.
  - `owner`: log2(N) bits.
  - `last`: log2(N) bits, the round-robin pointer.
  - `cnt`: ceil(log2(HOLD)) bits, minimum 1.
- Arbitration is combinational:
  - Winner is the first asserted `req` index searching `last+1`, `last+2`, …, wrapping modulo N and ending at `last`.
  - `last` itself therefore has lowest priority.
- IDLE:
  - If any `req` is high, go to GRANT at the next edge with `owner`=winner, `gnt`=one-hot(winner), `last`=winner, `cnt`=0.
  - Otherwise stay in IDLE with `gnt`=0.
- GRANT:
  - `en` = (`cnt`==0). Exactly one write per grant, in the first grant cycle.
  - `d` = `wdata[owner]` in every GRANT cycle. `d`=0 in IDLE.
  - `q` <= `d` on any edge where `en`=1. `q` holds otherwise.
  - Release condition: `cnt`==HOLD-1, or `req[owner]`==0.
  - No release: `cnt` <= `cnt`+1; `gnt`, `owner` unchanged.
  - Release with any `req` high (including the current owner's): re-arbitrate from the updated `last`=`owner`. Stay in GRANT with the new owner and `cnt`=0, so a new write happens in the next cycle. No idle bubble between grants.
  - Release with no `req` high: go to IDLE, `gnt`=0.
- A requester dropping `req` in its first grant cycle still gets its write, because `en` depends only on state and `cnt`. The grant is released at the end of that cycle.
- HOLD=1: every grant lasts one cycle. Continuous requests produce one write per cycle, rotating.

## Timing
- Reset (`rst`=0, asynchronous, immediate): state=IDLE, `gnt`=0, `en`=0, `d`=0, `busy`=0, `q`=0, `cnt`=0, `owner`=0, `last`=N-1. With `last`=N-1, index 0 has highest priority after reset.
- Reset release is synchronous to `clk`; the first arbitration uses `req` sampled on the first rising edge with `rst`=1.
- Latency from IDLE:
  - `req` high before edge k → `gnt`, `en`, `busy` high after edge k.
  - `q` updated after edge k+1.
- Grant duration: 1..HOLD cycles; HOLD cycles if `req[owner]` stays high.
- Back-to-back: the next owner's `gnt` appears on the same edge the previous one drops. `gnt` is never multi-hot.
- Reset asserted mid-grant aborts immediately. `q` returns to 0, and any in-flight write is lost.
- `req` and `wdata` changes are sampled only at `clk` edges. `d` follows `wdata[owner]` combinationally during GRANT.

## Test plan
- Reset check:
  - Stimulus: assert `rst`=0 mid-cycle with `req`=4'b1111.
  - Required: `gnt`=0, `en`=0, `q`=0, `busy`=0 immediately. After release, the first grant goes to index 0.
- Single requester (N=4, W=8, HOLD=2):
  - Stimulus: `req`=4'b0010, `wdata[1]`=8'h5A held.
  - Required: `gnt`=4'b0010 for 2 cycles with `en`=1 only in the first. `q`=8'h5A one cycle after `gnt` rises. `gnt` stays 4'b0010 for a second grant, with a rewrite, because the same requester is still the only one requesting.
- Full contention (HOLD=2):
  - Stimulus: `req`=4'b1111 held, `wdata[i]`=8'h10+i.
  - Required: owners 0,1,2,3,0, each held 2 cycles, with no gap. `q` sequence 8'h10, 8'h11, 8'h12, 8'h13, 8'h10.
- Early drop:
  - Stimulus: owner 2 drops `req` in its first grant cycle while `req[3]`=1.
  - Required: the write of `wdata[2]` still occurs. `gnt`=4'b1000 on the next edge.
- Pointer wrap and priority:
  - Stimulus: `last`=3 after a grant to 3, then `req`=4'b1001.
  - Required: grant goes to 0, not 3. Next, with `req`=4'b1001 still held, the grant goes to 3.
- Reset mid-grant:
  - Stimulus: `rst`=0 in the second cycle of a HOLD=2 grant.
  - Required: `gnt`=0, `q`=0 immediately. After release with `req`=4'b0100, `gnt`=4'b0100 one edge later.
